// File: rtl/pipeline_pkg.sv
// Types and constants shared by the fetch, decode and execute stages.
package pipeline_pkg;

    localparam int unsigned PIPE_XLEN = 32;

    // addi x0, x0, 0: the canonical RISC-V no-op.
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [PIPE_XLEN-1:0] pc;
        logic [PIPE_XLEN-1:0] instr;
    } fetch_entry_t;

endpackage : pipeline_pkg

// File: rtl/fetch_queue.sv
// Show-ahead FIFO that decouples instruction fetch from decode.
// Holds {pc, instr} pairs and drops everything in one cycle on a flush.
module fetch_queue
    import pipeline_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned XLEN  = PIPE_XLEN
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [XLEN-1:0]            in_instr,
    output logic                       in_ready,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [XLEN-1:0]            out_pc,
    output logic [XLEN-1:0]            out_instr,
    output logic [6:0]                 op_6_0,
    output logic [2:0]                 funct3,
    output logic                       funct7_5,
    output logic [4:0]                 funct7_2_6,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    fetch_entry_t     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push, pop;

    // Handshakes look only at registered count and flush, so out_ready never reaches in_ready.
    assign in_ready  = (count_q != FULL_COUNT) && !flush;
    assign out_valid = (count_q != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;
    assign count     = count_q;

    always_comb begin
        // NOTE: every always_comb output gets a default first so no path can infer a latch.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            if (push && !pop)      count_d = count_q + 1'b1;
            else if (pop && !push) count_d = count_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; out_valid masks stale contents.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q].pc    <= in_pc;
            mem_q[wr_ptr_q].instr <= in_instr;
        end
    end

    always_comb begin
        out_pc    = '0;
        out_instr = XLEN'(NOP_INSTR);
        if (out_valid) begin
            out_pc    = mem_q[rd_ptr_q].pc;
            out_instr = mem_q[rd_ptr_q].instr;
        end
    end

    assign op_6_0     = out_instr[6:0];
    assign funct3     = out_instr[14:12];
    assign funct7_5   = out_instr[30];
    assign funct7_2_6 = out_instr[31:27];

endmodule : fetch_queue

// File: doc/fetch_queue.md
# fetch_queue

Decoupling FIFO between the instruction-fetch stage and the decode stage. It buffers fetched {pc, instruction} pairs so that fetch keeps running while decode is stalled. It presents the head entry to decode with the opcode/funct slices already split out for the control unit. A flush from branch/jump resolution discards every buffered entry in one cycle.

## Interface
Parameters:
- DEPTH, 4, number of entries; power of two, ≥ 2
- XLEN, 32, width of pc and instruction

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; asynchronous, active-high
- in_valid  in  1  fetch offers an entry this cycle
- in_pc  in  XLEN  pc of offered instruction
- in_instr  in  XLEN  offered instruction word
- in_ready  out  1  queue accepts the entry this cycle
- out_valid  out  1  head entry valid for decode
- out_ready  in  1  decode consumes the head this cycle
- out_pc  out  XLEN  head pc
- out_instr  out  XLEN  head instruction; NOP when empty
- op_6_0  out  7  out_instr[6:0]
- funct3  out  3  out_instr[14:12]
- funct7_5  out  1  out_instr[30]
- funct7_2_6  out  5  out_instr[31:27]
- flush  in  1  discard all entries (branch/jump redirect)
- count  out  $clog2(DEPTH+1)  current occupancy

## Operation
- Storage: DEPTH-entry array of fetch_entry_t, with wr_ptr, rd_ptr ($clog2(DEPTH) bits) and count. Both pointers wrap modulo DEPTH by natural overflow.
- push = in_valid & in_ready; pop = out_valid & out_ready.
- in_ready = (count != DEPTH) & ~flush. A full queue accepts nothing, even when a pop happens in the same cycle (no pass-through when full).
- out_valid = (count != 0). out_pc/out_instr read combinationally from entry[rd_ptr] (show-ahead).
- When count == 0, out_instr = NOP (32'h0000_0013) and out_pc = 0, so the decode field slices are benign.
- push only: write entry[wr_ptr], wr_ptr+1, count+1.
- pop only: rd_ptr+1, count−1.
- push and pop together: both pointers advance, count unchanged. Legal whenever 0 < count < DEPTH.
- flush has priority over everything: rd_ptr, wr_ptr and count go to 0 at the next edge. Any push or pop in that cycle is ignored.
- Storage array contents are not reset. Only pointers and count are reset.
- out_ready while empty has no effect. in_valid while in_ready=0 has no effect, and the entry must be re-offered by fetch.
- Pushing into an empty queue never forwards the entry to the output in the same cycle.

## Timing
- Reset (asynchronous assert): wr_ptr = rd_ptr = 0, count = 0, out_valid = 0, in_ready = 1, out_instr = NOP, out_pc = 0, count output = 0. Release is synchronous to clk in the enclosing design.
- Latency: an entry pushed at edge N is visible on out_* after edge N, so decode sees it one cycle after it is offered.
- in_ready and out_valid depend only on registered count plus flush. There is no combinational path from out_ready to in_ready.
- flush asserted in cycle N: in_ready = 0 in cycle N, and the queue is empty after edge N. A fetch from the redirected pc can be pushed in cycle N+1.
- Throughput: one push and one pop per cycle sustained while not full.

## Structure
- pipeline_pkg holds typedef fetch_entry_t {logic [XLEN-1:0] pc; logic [XLEN-1:0] instr;} and the constant NOP_INSTR = 32'h0000_0013. Decode and execute share both.
- Field slicing is plain assigns in this module. The control unit instantiates downstream of it unchanged.
- Single module, no sub-module. Pointer/count logic is one always_ff block and output muxing is always_comb.

## Test plan
- Reset then idle: rst pulse → out_valid=0, in_ready=1, count=0, out_instr=32'h00000013, op_6_0=7'h13.
- Fill: push pc 0x0,0x4,0x8,0xC with out_ready=0 → count=4, in_ready=0. A fifth push at pc 0x10 is not accepted. out_pc stays 0x0.
- Drain with wrap: from full, pop 2 and push 0x10, 0x14. Then pop continuously → pcs come out 0x8, 0xC, 0x10, 0x14 in order, wr_ptr has wrapped, and count ends at 0.
- Simultaneous push/pop at count=2 → count stays 2, output order preserved. Full with out_ready=1 and in_valid=1 → pop only, count=3.
- Flush: count=3 with flush=1, in_valid=1 (pc 0x100) and out_ready=1 → next cycle count=0, out_valid=0, and 0x100 is not stored. Pushing 0x100 in the following cycle appears at the output one cycle later.
- Field slicing: push instr 32'h4020_80B3 (sub) → funct7_5=1, funct3=0, op_6_0=7'h33, funct7_2_6=5'b01000.
- Async reset mid-operation: count=3, rst asserted between edges → outputs return to reset values immediately, and the first push after release appears at rd_ptr 0.
